// File: rtl/link_sequencer.sv
// link_sequencer: frame-level controller for the serializer -> channel ->
// deserializer path. It accepts one frame request at a time and runs ser_en for
// FRAME_BITS cycles. It runs deser_en for FRAME_BITS cycles, starting DELAY
// cycles after serialization begins. A frame ends with a frame_done pulse, or
// with an aborted pulse if abort cancels it.
// Optional feature macro: LINK_SEQ_FRAME_COUNT_EN adds a 16-bit completed-frame
// counter (frame_count) with a synchronous clear (count_clr).
// All outputs are registered. They are computed from next-state values, so they
// match a decode of the current state and counter, with no decode glitches.

module link_sequencer #(
    parameter int FRAME_BITS = 16,
    parameter int DELAY      = 47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        abort,
    output logic        ser_en,
    output logic        deser_en,
    output logic        busy,
    output logic        frame_done,
    output logic        aborted
`ifdef LINK_SEQ_FRAME_COUNT_EN
    ,
    input  logic        count_clr,
    output logic [15:0] frame_count
`endif
);

    localparam int CW = $clog2(DELAY + FRAME_BITS + 1);

    localparam logic [CW-1:0] END_C  = CW'(DELAY + FRAME_BITS - 1);
    localparam logic [CW-1:0] FB_C   = CW'(FRAME_BITS);
    localparam logic [CW-1:0] DL_C   = CW'(DELAY);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;

    // Next counter value while a frame is running (never wraps: stops at END_C).
    always_comb begin
        cnt_inc_s = cnt_r + ONE_C;
    end

    // Sequencer FSM: state, frame counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= ZERO_C;
            req_ready  <= 1'b1;
            ser_en     <= 1'b0;
            deser_en   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_done <= 1'b0;
                    aborted    <= 1'b0;
                    // abort is ignored here; a request is always taken.
                    if (req_valid && req_ready) begin
                        state_r   <= RUN;
                        cnt_r     <= ZERO_C;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        ser_en    <= (ZERO_C < FB_C);
                        deser_en  <= (ZERO_C >= DL_C);
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        ser_en    <= 1'b0;
                        deser_en  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Cancel: the next cycle is IDLE and can accept a request.
                        state_r    <= IDLE;
                        cnt_r      <= ZERO_C;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        ser_en     <= 1'b0;
                        deser_en   <= 1'b0;
                        frame_done <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (cnt_r == END_C) begin
                        state_r    <= DONE;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        ser_en     <= 1'b0;
                        deser_en   <= 1'b0;
                        frame_done <= 1'b1;
                        aborted    <= 1'b0;
                    end else begin
                        cnt_r      <= cnt_inc_s;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        ser_en     <= (cnt_inc_s < FB_C);
                        deser_en   <= (cnt_inc_s >= DL_C);
                        frame_done <= 1'b0;
                        aborted    <= 1'b0;
                    end
                end
                DONE: begin
                    // Single-cycle completion state; abort has no effect here.
                    state_r    <= IDLE;
                    cnt_r      <= ZERO_C;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    ser_en     <= 1'b0;
                    deser_en   <= 1'b0;
                    frame_done <= 1'b0;
                    aborted    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= ZERO_C;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    ser_en     <= 1'b0;
                    deser_en   <= 1'b0;
                    frame_done <= 1'b0;
                    aborted    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LINK_SEQ_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Completed-frame counter; clear wins over a same-cycle increment, wraps at 0xFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 16'h0000;
        end else if (count_clr) begin
            frame_count_r <= 16'h0000;
        end else if (frame_done) begin
            frame_count_r <= frame_count_r + 16'h0001;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_link_sequencer.sv
// Testbench for link_sequencer: instance A uses the default 16/47 timing and
// instance B uses 8/4. Each scoreboard entry carries the inputs for one clock
// edge and the output vector expected in the following cycle. The expected
// vector is {req_ready, busy, ser_en, deser_en, frame_done, aborted}.

module tb_link_sequencer;

    logic clk;
    logic reset;
    logic req_valid_a, abort_a, req_valid_b, abort_b, count_clr;
    logic req_ready_a, ser_en_a, deser_en_a, busy_a, frame_done_a, aborted_a;
    logic req_ready_b, ser_en_b, deser_en_b, busy_b, frame_done_b, aborted_b;
`ifdef LINK_SEQ_FRAME_COUNT_EN
    logic [15:0] frame_count_a, frame_count_b;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] IDLE_V = 6'b100000;
    localparam logic [5:0] ABRT_V = 6'b100001;

    typedef struct {
        bit         sel_b;
        bit         rst;
        bit         valid;
        bit         abrt;
        bit         clr;
        logic [5:0] exp;
    } ent_t;

    ent_t sb_q[$];

    link_sequencer #(.FRAME_BITS(16), .DELAY(47)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .abort(abort_a), .ser_en(ser_en_a), .deser_en(deser_en_a), .busy(busy_a),
        .frame_done(frame_done_a), .aborted(aborted_a)
`ifdef LINK_SEQ_FRAME_COUNT_EN
        , .count_clr(count_clr), .frame_count(frame_count_a)
`endif
    );

    link_sequencer #(.FRAME_BITS(8), .DELAY(4)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .abort(abort_b), .ser_en(ser_en_b), .deser_en(deser_en_b), .busy(busy_b),
        .frame_done(frame_done_b), .aborted(aborted_b)
`ifdef LINK_SEQ_FRAME_COUNT_EN
        , .count_clr(count_clr), .frame_count(frame_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in cycle c after an accepting edge (c=1 is the first RUN cycle).
    function automatic logic [5:0] expv(int c, int f, int d);
        if (c >= 1 && c <= d + f)
            return {1'b0, 1'b1, (c <= f) ? 1'b1 : 1'b0, (c >= d + 1) ? 1'b1 : 1'b0, 1'b0, 1'b0};
        else if (c == d + f + 1)
            return 6'b010010;
        else
            return IDLE_V;
    endfunction

    task automatic push(bit sel, bit rst, bit v, bit ab, bit clr, logic [5:0] ex);
        ent_t e;
        e.sel_b = sel; e.rst = rst; e.valid = v; e.abrt = ab; e.clr = clr; e.exp = ex;
        sb_q.push_back(e);
    endtask

    // One complete frame: request on entry 0, ends with the first idle cycle.
    task automatic push_frame(bit sel, int f, int d, int clr_at);
        for (int e = 0; e <= d + f + 1; e++)
            push(sel, 1'b0, e == 0, 1'b0, e == clr_at, expv(e + 1, f, d));
    endtask

    // Apply one entry's inputs across a clock edge, then sample on the falling edge.
    task automatic run_edge(input ent_t e, output logic [5:0] obs);
        reset       = e.rst;
        req_valid_a = e.valid & ~e.sel_b;
        abort_a     = e.abrt & ~e.sel_b;
        req_valid_b = e.valid & e.sel_b;
        abort_b     = e.abrt & e.sel_b;
        count_clr   = e.clr;
        @(posedge clk);
        @(negedge clk);
        obs = e.sel_b ? {req_ready_b, busy_b, ser_en_b, deser_en_b, frame_done_b, aborted_b}
                      : {req_ready_a, busy_a, ser_en_a, deser_en_a, frame_done_a, aborted_a};
    endtask

    task automatic test_reset();
        ent_t e; logic [5:0] obs; int i = 0;
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, IDLE_V);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE_V);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_V);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_V);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, e.exp);
            end
            i++;
        end
    endtask

    task automatic test_single_frame();
        ent_t e; logic [5:0] obs; int i = 0;
        push_frame(1'b0, 16, 47, -1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL single_frame cycle %0d: got %b expected %b", i + 1, obs, e.exp);
            end
            i++;
        end
    endtask

    task automatic test_overlap();
        ent_t e; logic [5:0] obs; int i = 0;
        push_frame(1'b1, 8, 4, -1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_V);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL overlap cycle %0d: got %b expected %b", i + 1, obs, e.exp);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e; logic [5:0] obs; int i = 0;
        for (int k = 0; k <= 129; k++)
            push(1'b0, 1'b0, k <= 99, 1'b0, 1'b0,
                 (k + 1 <= 65) ? expv(k + 1, 16, 47) : expv(k + 1 - 65, 16, 47));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i + 1, obs, e.exp);
            end
            i++;
        end
    endtask

    task automatic test_abort();
        ent_t e; logic [5:0] obs; int i = 0;
        logic [5:0] ex;
        bit v, ab;
        for (int k = 0; k <= 104; k++) begin
            int c = k + 1;
            v  = (k == 0) || (k == 31) || (k == 100);
            ab = (k == 30) || (k >= 95 && k <= 101);
            if (c <= 30)       ex = expv(c, 16, 47);
            else if (c == 31)  ex = ABRT_V;
            else if (c <= 96)  ex = expv(c - 31, 16, 47);
            else if (c <= 100) ex = IDLE_V;
            else if (c == 101) ex = expv(1, 16, 47);
            else if (c == 102) ex = ABRT_V;
            else               ex = IDLE_V;
            push(1'b0, 1'b0, v, ab, 1'b0, ex);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL abort cycle %0d: got %b expected %b", i + 1, obs, e.exp);
            end
            i++;
        end
    endtask

    task automatic test_reset_midframe();
        ent_t e; logic [5:0] obs; int i = 0;
        for (int k = 0; k <= 69; k++)
            push(1'b0, k == 50, k == 0, 1'b0, 1'b0, (k + 1 <= 50) ? expv(k + 1, 16, 47) : IDLE_V);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_midframe cycle %0d: got %b expected %b", i + 1, obs, e.exp);
            end
            i++;
        end
    endtask

`ifdef LINK_SEQ_FRAME_COUNT_EN
    task automatic test_frame_count();
        ent_t e; logic [5:0] obs; int i = 0;
        // Clear, three full frames, then one aborted frame.
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE_V);
        for (int n = 0; n < 3; n++) push_frame(1'b0, 16, 47, -1);
        for (int k = 0; k <= 12; k++)
            push(1'b0, 1'b0, k == 0, k == 10, 1'b0,
                 (k + 1 <= 10) ? expv(k + 1, 16, 47) : ((k + 1 == 11) ? ABRT_V : IDLE_V));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL frame_count_seq step %0d: got %b expected %b", i, obs, e.exp);
            end
            i++;
        end
        checks++;
        if (frame_count_a !== 16'd3) begin
            errors++;
            $display("FAIL frame_count_three: got %0d expected 3", frame_count_a);
        end
        // Clear on the edge that ends the DONE cycle beats the increment.
        push_frame(1'b0, 16, 47, 64);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
        end
        checks++;
        if (frame_count_a !== 16'd0) begin
            errors++;
            $display("FAIL frame_count_clr_priority: got %0d expected 0", frame_count_a);
        end
        // Wrap from 0xFFFF to 0x0000.
        force dut_a.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release dut_a.frame_count_r;
        push_frame(1'b0, 16, 47, -1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            run_edge(e, obs);
        end
        checks++;
        if (frame_count_a !== 16'h0000) begin
            errors++;
            $display("FAIL frame_count_wrap: got %h expected 0000", frame_count_a);
        end
    endtask
`endif

    // Test sequence.
    initial begin
        reset = 1'b1; req_valid_a = 1'b0; abort_a = 1'b0;
        req_valid_b = 1'b0; abort_b = 1'b0; count_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_overlap();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
`ifdef LINK_SEQ_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
